// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: checker state encoding and the default LFSR
// length, feedback mask and seed used by the generator/checker pair.
package prbs_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam int unsigned PRBS_WIDTH = 3;
    localparam logic [PRBS_WIDTH-1:0] PRBS_TAPS = 3'b111;
    localparam logic [PRBS_WIDTH-1:0] PRBS_SEED = 3'b100;

endpackage

// File: rtl/prbs_predict.sv
// Combinational next-bit predictor: parity of the history bits selected by TAPS.
module prbs_predict
    import prbs_pkg::*;
#(
    parameter int unsigned           WIDTH = PRBS_WIDTH,
    parameter logic [WIDTH-1:0]      TAPS  = WIDTH'(PRBS_TAPS)
) (
    input  logic [WIDTH-1:0] hist,
    output logic             pred_c
);

    assign pred_c = ^(hist & TAPS);

endmodule

// File: rtl/prbs_checker.sv
// Serial PRBS checker: self-synchronises to the incoming stream, declares
// lock, then counts bit errors against a locally regenerated sequence.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int unsigned      WIDTH      = PRBS_WIDTH,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(PRBS_TAPS),
    parameter int unsigned      LOCK_CNT   = 8,
    parameter int unsigned      UNLOCK_CNT = 4,
    parameter int unsigned      ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int unsigned FILL_W  = $clog2(WIDTH + 1);
    localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned BAD_W   = $clog2(UNLOCK_CNT + 1);
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [BAD_W-1:0]   bad_q, bad_d;
    logic               locked_q, locked_d;
    logic               err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic               pred_c;

    prbs_predict #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_predict (
        .hist   (hist_q),
        .pred_c (pred_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SEARCH;
            hist_q      <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            bad_q       <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            bad_q       <= bad_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Clear is applied first so a same-cycle counted error leaves err_cnt at 1.
    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        fill_d      = fill_q;
        match_d     = match_q;
        bad_d       = bad_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = clr_cnt ? '0 : err_cnt_q;

        if (in_valid) begin
            case (state_q)
                SEARCH: begin
                    hist_d = {hist_q[WIDTH-2:0], in_bit};
                    if (fill_q < FILL_W'(WIDTH)) begin
                        fill_d = fill_q + FILL_W'(1);
                    end else if (in_bit == pred_c) begin
                        if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                            match_d  = '0;
                            bad_d    = '0;
                        end else begin
                            match_d = match_q + MATCH_W'(1);
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    // Regenerate locally so a line error does not poison the history.
                    hist_d = {hist_q[WIDTH-2:0], pred_c};
                    if (in_bit == pred_c) begin
                        bad_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        if (err_cnt_d != ERR_MAX) begin
                            err_cnt_d = err_cnt_d + ERR_W'(1);
                        end
                        if (bad_q == BAD_W'(UNLOCK_CNT - 1)) begin
                            state_d  = SEARCH;
                            locked_d = 1'b0;
                            fill_d   = '0;
                            match_d  = '0;
                            bad_d    = '0;
                        end else begin
                            bad_d = bad_q + BAD_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: lock, single error, loss of lock, gapped
// valid, counter saturation/clear and asynchronous reset.
module tb_prbs_checker;

    logic        clk;
    logic        rst;
    logic        a_valid, a_bit, a_clr;
    logic        a_locked, a_pulse;
    logic [15:0] a_cnt;
    logic        s_valid, s_bit, s_clr;
    logic        s_locked, s_pulse;
    logic [3:0]  s_cnt;

    int          n_checks;
    int          n_errors;
    int          a_ph;
    int          s_ph;
    int          pulses;
    int          nv;
    logic [3:0]  pat;

    prbs_checker dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_valid),
        .in_bit    (a_bit),
        .clr_cnt   (a_clr),
        .locked    (a_locked),
        .err_pulse (a_pulse),
        .err_cnt   (a_cnt)
    );

    prbs_checker #(
        .ERR_W      (4),
        .UNLOCK_CNT (100)
    ) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_valid),
        .in_bit    (s_bit),
        .clr_cnt   (s_clr),
        .locked    (s_locked),
        .err_pulse (s_pulse),
        .err_cnt   (s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock of stimulus to one instance; gap cycles carry a wrong bit on purpose.
    task automatic step(input bit sel, input logic v, input logic flip, input logic clr);
        if (!sel) begin
            a_valid = v;
            a_clr   = clr;
            a_bit   = v ? (pat[a_ph % 4] ^ flip) : ~pat[a_ph % 4];
            if (v) a_ph++;
            s_valid = 1'b0;
            s_clr   = 1'b0;
        end else begin
            s_valid = v;
            s_clr   = clr;
            s_bit   = v ? (pat[s_ph % 4] ^ flip) : ~pat[s_ph % 4];
            if (v) s_ph++;
            a_valid = 1'b0;
            a_clr   = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic relock(input string tag);
        for (int i = 1; i <= 11; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            if (i >= 10) check($sformatf("%s_bit%0d_locked", tag, i), 32'(a_locked), 32'(i == 11));
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        a_ph     = 0;
        s_ph     = 0;
        pat      = 4'b1001;
        rst      = 1'b1;
        a_valid  = 1'b0;
        a_bit    = 1'b0;
        a_clr    = 1'b0;
        s_valid  = 1'b0;
        s_bit    = 1'b0;
        s_clr    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_locked", 32'(a_locked), 32'd0);
        check("rst_pulse",  32'(a_pulse),  32'd0);
        check("rst_cnt",    32'(a_cnt),    32'd0);
        rst = 1'b0;

        // Clean lock: 3 fill bits then 8 matches.
        for (int i = 1; i <= 11; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            check($sformatf("lock_bit%0d_locked", i), 32'(a_locked), 32'(i == 11));
        end
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            pulses += int'(a_pulse);
        end
        check("clean_pulses", 32'(pulses),   32'd0);
        check("clean_cnt",    32'(a_cnt),    32'd0);
        check("clean_locked", 32'(a_locked), 32'd1);

        // Single flipped bit.
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("flip_pulse",  32'(a_pulse),  32'd1);
        check("flip_cnt",    32'(a_cnt),    32'd1);
        check("flip_locked", 32'(a_locked), 32'd1);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            pulses += int'(a_pulse);
        end
        check("after_flip_pulses", 32'(pulses),   32'd0);
        check("after_flip_cnt",    32'(a_cnt),    32'd1);
        check("after_flip_locked", 32'(a_locked), 32'd1);

        // Clear alone on an idle cycle.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_idle_cnt",    32'(a_cnt),    32'd0);
        check("clr_idle_locked", 32'(a_locked), 32'd1);

        // Loss of lock after four consecutive errors.
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
            check($sformatf("loss%0d_pulse", i),  32'(a_pulse),  32'd1);
            check($sformatf("loss%0d_locked", i), 32'(a_locked), 32'(i < 4));
        end
        check("loss_cnt", 32'(a_cnt), 32'd4);
        relock("relock");
        check("relock_cnt", 32'(a_cnt), 32'd4);

        // Gapped valid from a fresh reset: valid every third cycle.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        nv = 0;
        for (int c = 0; c < 60 && nv < 11; c++) begin
            step(1'b0, logic'(c % 3 == 0), 1'b0, 1'b0);
            if (c % 3 == 0) nv++;
            check($sformatf("gap_c%0d_locked", c), 32'(a_locked), 32'(nv >= 11));
        end
        check("gap_valid_bits", 32'(nv), 32'd11);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        check("gap_hold_locked", 32'(a_locked), 32'd1);
        check("gap_hold_cnt",    32'(a_cnt),    32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("gap_resume_pulse", 32'(a_pulse), 32'd0);

        // Saturation and clear on the narrow-counter instance.
        for (int i = 0; i < 11; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        check("sat_locked", 32'(s_locked), 32'd1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
        check("sat_cnt",        32'(s_cnt),    32'd15);
        check("sat_locked_err", 32'(s_locked), 32'd1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("sat_clr_err_cnt",   32'(s_cnt),   32'd1);
        check("sat_clr_err_pulse", 32'(s_pulse), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("sat_clr_cnt", 32'(s_cnt), 32'd0);

        // Asynchronous reset mid-lock, off the clock edge.
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("pre_rst_pulse", 32'(a_pulse), 32'd1);
        check("pre_rst_cnt",   32'(a_cnt),   32'd1);
        #2;
        a_valid = 1'b0;
        rst     = 1'b1;
        #1;
        check("arst_locked", 32'(a_locked), 32'd0);
        check("arst_cnt",    32'(a_cnt),    32'd0);
        check("arst_pulse",  32'(a_pulse),  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        relock("arst_relock");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Serial receiver-side checker for the pseudo-random bit stream produced by our LFSR generator.
- Sits directly downstream of the generator's serial output.
- Self-synchronises to the incoming stream, declares lock, then counts bit errors against its own locally regenerated sequence.
- Used to verify link and channel integrity in the lab designs.

Parameters:
- WIDTH, 3, LFSR length; must equal the generator's register length.
- TAPS, 3'b111, feedback mask. Predicted bit = XOR of (hist & TAPS).
- LOCK_CNT, 8, consecutive correct predictions required to enter LOCKED.
- UNLOCK_CNT, 4, consecutive mispredictions in LOCKED that force SEARCH.
- ERR_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_bit is sampled this cycle; when low, all state holds.
- in_bit  in  1  received serial bit (generator out).
- clr_cnt  in  1  synchronous clear of err_cnt.
- locked  out  1  registered; 1 while in LOCKED.
- err_pulse  out  1  registered; one-cycle pulse for each mismatch counted in LOCKED.
- err_cnt  out  ERR_W  registered, saturating error count.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high. On rst, all state clears: hist=0, fill=0, match_cnt=0, bad_cnt=0, state=SEARCH, locked=0, err_pulse=0, err_cnt=0.
- hist[WIDTH-1:0] holds past bits: hist[0] newest, hist[WIDTH-1] oldest. On each shift, hist <= {hist[WIDTH-2:0], new}.
- Predicted bit p = ^(hist & TAPS). This is the generator recurrence s[n+3]=s[n+2]^s[n+1]^s[n] for the defaults.
- Nothing changes in a cycle with in_valid=0, except clr_cnt and the err_pulse return to 0.
- SEARCH:
  - Shift in_bit into hist.
  - While fill<WIDTH: fill++, no comparison made.
  - Once fill==WIDTH: compare in_bit to p. On match, match_cnt++; on mismatch, match_cnt<=0.
  - When a match makes match_cnt reach LOCK_CNT: go to LOCKED, set locked=1 at the next edge, and clear match_cnt and bad_cnt.
  - No errors are counted in SEARCH.
- LOCKED:
  - Shift p (not in_bit) into hist, so a single line error does not propagate.
  - Match: bad_cnt<=0.
  - Mismatch: err_pulse=1 next cycle; err_cnt++ (saturates at 2^ERR_W-1); bad_cnt++.
  - When bad_cnt reaches UNLOCK_CNT: go to SEARCH with locked=0, fill=0, match_cnt=0. The offending bit is still counted.
- Latency: err_pulse and locked are valid at the edge after the sampled bit.
- clr_cnt in the same cycle as a counted error: err_cnt=1 (clear, then count). clr_cnt alone: err_cnt=0.
- All-zero lockup: if hist is all zero in LOCKED, behaviour follows the rules above (every 1 on the line is an error). There is no special case.
- Reset mid-lock aborts immediately and asynchronously to the reset values.

Decomposition:
- Shared package prbs_pkg:
  - state enum {SEARCH, LOCKED}.
  - Default WIDTH/TAPS/seed constants, shared with the generator.
- One natural sub-module: prbs_predict.
  - Combinational.
  - Takes hist and TAPS, returns p.
  - Reusable by later generator variants.
- Counters and the FSM stay in prbs_checker.

Test Plan:
- Clean lock (defaults):
  - Stimulus: generator seed 3'b100 drives stream 1,0,0,1 repeating, in_valid=1 every cycle.
  - First compare on bit 4; match_cnt reaches 8 on bit 11; locked=1 the following cycle.
  - err_cnt=0 and err_pulse never high over 100 further bits.
- Single flip while locked:
  - Stimulus: invert one bit.
  - Exactly one err_pulse; err_cnt=1; locked stays 1; no further pulses.
- Loss of lock:
  - Stimulus: invert 4 consecutive bits.
  - err_cnt=4; locked=0 the cycle after the 4th; with a clean stream, relock after 3+8 bits.
- Gapped valid:
  - Stimulus: in_valid toggling 1,0,0,1… over a clean stream.
  - Lock reached after the same 11 valid bits regardless of gaps; held state verified during gaps.
- Saturation and clear:
  - Stimulus: ERR_W=4 and UNLOCK_CNT=100, inject 20 errors.
  - err_cnt=15 (saturated).
  - clr_cnt with a simultaneous error gives err_cnt=1; clr_cnt alone gives 0.
- Async reset:
  - Stimulus: assert rst mid-lock, off a clk edge.
  - locked, err_cnt and err_pulse go to 0 immediately; relock follows the clean-lock timing after release.
